grid_mem_arbiter: RTL

Shares the placement engine's single-port grid RAM (cell → node id, empty = all-ones) among up to NREQ placement workers. It performs round-robin arbitration and issues memory reads and writes. It also provides an atomic claim operation: test a cell for empty and write it, indivisibly, so concurrent workers can never place two nodes in one cell. It sits between the worker FSMs and the grid memoryRAM instance.

---
 rtl/grid_mem_arbiter_if.sv | 36 +++
 rtl/grid_mem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/grid_mem_arbiter_if.sv
// Request/response and grid-RAM bundle between the placement workers and
// grid_mem_arbiter. The arbiter sits on the slave side of this bundle.
interface grid_mem_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Handshake: request i moves in a cycle where req_valid[i] & req_ready[i];
  // the requester holds op/addr/wdata stable until then and may drop valid
  // beforehand to withdraw. rsp_valid is a one-cycle strobe that cannot stall.
  logic [NREQ-1:0]        req_valid;
  logic [2*NREQ-1:0]      req_op;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_ok;
  logic                   mem_re;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_ok,
           mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_ok,
           mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/grid_mem_arbiter.sv
// Round-robin arbiter for the single-port grid RAM, with an atomic
// test-for-empty-and-write claim that holds off every other access.
module grid_mem_arbiter #(
  parameter int              NREQ   = 4,
  parameter int              ADDR_W = 12,
  parameter int              DATA_W = 32,
  parameter logic [DATA_W-1:0] EMPTY = {DATA_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  grid_mem_arbiter_if.slave        bus,
  output logic [15:0]              claim_fail_cnt,
  output logic [1:0]               dbg_state,
  output logic [$clog2(NREQ)-1:0]  dbg_rr_ptr
);
  localparam int PW = $clog2(NREQ);
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_CL = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, CL_CHK = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_ok_q, rsp_ok_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                found;
  logic [PW-1:0]       winner;
  logic [PW:0]         idx_w;
  logic [1:0]          win_op;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  // First valid requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx_w  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (idx_w >= (PW+1)'(NREQ)) idx_w = idx_w - (PW+1)'(NREQ);
      if (!found && bus.req_valid[idx_w[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx_w[PW-1:0];
      end
    end
  end

  always_comb begin
    win_op    = '0;
    win_addr  = '0;
    win_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner == PW'(k)) begin
        win_op    = bus.req_op[2*k +: 2];
        win_addr  = bus.req_addr[k*ADDR_W +: ADDR_W];
        win_wdata = bus.req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    rsp_ok_d      = rsp_ok_q;
    cnt_d         = cnt_q;
    bus.req_ready = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            bus.req_ready = NREQ'(1) << winner;
            rr_ptr_d      = (winner == PW'(NREQ-1)) ? '0 : winner + PW'(1);
            idx_d         = winner;
            bus.mem_addr  = win_addr;
            if (win_op == OP_WR) begin
              bus.mem_we    = 1'b1;
              bus.mem_wdata = win_wdata;
              rsp_valid_d   = NREQ'(1) << winner;
              rsp_ok_d      = 1'b1;
            end else if (win_op == OP_CL) begin
              bus.mem_re = 1'b1;
              addr_d     = win_addr;
              wdata_d    = win_wdata;
              state_d    = CL_CHK;
            end else begin
              bus.mem_re = 1'b1;
              state_d    = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          rsp_valid_d = NREQ'(1) << idx_q;
          rsp_data_d  = bus.mem_rdata;
          rsp_ok_d    = 1'b1;
          state_d     = IDLE;
        end
        CL_CHK: begin
          // Nothing else was granted since the read, so this write is atomic.
          rsp_valid_d = NREQ'(1) << idx_q;
          if (bus.mem_rdata == EMPTY) begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = addr_q;
            bus.mem_wdata = wdata_q;
            rsp_ok_d      = 1'b1;
            rsp_data_d    = EMPTY;
          end else begin
            rsp_ok_d   = 1'b0;
            rsp_data_d = bus.mem_rdata;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_ok_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ok_q    <= rsp_ok_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_ok     = rsp_ok_q;
  assign claim_fail_cnt = cnt_q;
  assign dbg_state      = state_q;
  assign dbg_rr_ptr     = rr_ptr_q;
endmodule
